// File: rtl/writeback_arbiter.sv
// writeback_arbiter
//   Drives the single register-file write port. The in-order pipeline WB stage
//   always wins the slot; long-latency results (mul/div/load miss) are queued
//   in a small FIFO and drained in slots the pipeline leaves idle. A starvation
//   counter asks upstream to idle WB for a slot once the FIFO has been passed
//   over STARVE_MAX times in a row. Pending writes are reported for hazard
//   checks.
//
//   Optional feature macro: WB_FORWARD_EN (adds fwd_hit_o / fwd_data_o and
//   narrows chk_pend_o to FIFO entries only).
//
//   Ports:
//     clk_i, rst_n_i                   clock (posedge), async active-low reset
//     pipe_valid_i/addr_i/data_i       pipeline WB write request
//     lu_valid_i/addr_i/data_i, lu_ready_o   long-latency result handshake
//     write_ctrl_o/addr_o/data_o       registered register-file write port
//     pipe_stall_o                     ask upstream to leave one WB slot idle
//     chk_addr_i, chk_pend_o           hazard query: write pending to address
//     count_o                          FIFO occupancy
//     fwd_hit_o, fwd_data_o            (WB_FORWARD_EN only) output-register forward
module writeback_arbiter #(
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       pipe_valid_i,
    input  logic [4:0]                 pipe_addr_i,
    input  logic [DATA_W-1:0]          pipe_data_i,
    input  logic                       lu_valid_i,
    output logic                       lu_ready_o,
    input  logic [4:0]                 lu_addr_i,
    input  logic [DATA_W-1:0]          lu_data_i,
    output logic                       write_ctrl_o,
    output logic [4:0]                 write_addr_o,
    output logic [DATA_W-1:0]          write_data_o,
    output logic                       pipe_stall_o,
    input  logic [4:0]                 chk_addr_i,
    output logic                       chk_pend_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
`ifdef WB_FORWARD_EN
    ,
    output logic                       fwd_hit_o,
    output logic [DATA_W-1:0]          fwd_data_o
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX+1) : 1;
    localparam logic [CW-1:0] FULL  = CW'(DEPTH);
    localparam logic [SW-1:0] S_LIM = SW'(STARVE_MAX);

    logic [4:0]        addr_mem_q [DEPTH];
    logic [DATA_W-1:0] data_mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic              stall_q, stall_d;
    logic              write_ctrl_q, write_ctrl_d;
    logic [4:0]        write_addr_q, write_addr_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;

    logic pipe_win, fifo_empty, push, pop;
    logic fifo_hit, out_hit;
    logic [PW-1:0] offset;

    assign lu_ready_o   = (count_q != FULL);
    assign fifo_empty   = (count_q == '0);
    assign pipe_win     = pipe_valid_i && (pipe_addr_i != 5'd0);
    // r0 results are accepted (handshake completes) but never stored.
    assign push         = lu_valid_i && lu_ready_o && (lu_addr_i != 5'd0);
    assign pop          = !pipe_win && !fifo_empty;

    assign write_ctrl_o = write_ctrl_q;
    assign write_addr_o = write_addr_q;
    assign write_data_o = write_data_q;
    assign pipe_stall_o = stall_q;
    assign count_o      = count_q;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        starve_d     = starve_q;
        stall_d      = stall_q;
        write_ctrl_d = 1'b0;
        write_addr_d = write_addr_q;
        write_data_d = write_data_q;

        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (pipe_win) begin
            write_ctrl_d = 1'b1;
            write_addr_d = pipe_addr_i;
            write_data_d = pipe_data_i;
        end else if (pop) begin
            write_ctrl_d = 1'b1;
            write_addr_d = addr_mem_q[rd_ptr_q];
            write_data_d = data_mem_q[rd_ptr_q];
        end

        // Non-empty and no pop means the pipe took the slot. Counter saturates
        // at the limit; with STARVE_MAX=0 the limit is 0 so it never moves.
        if (pop || fifo_empty) begin
            starve_d = '0;
        end else if (starve_q != S_LIM) begin
            starve_d = starve_q + SW'(1);
        end

        if (pop) begin
            stall_d = 1'b0;
        end else if ((STARVE_MAX != 0) && !fifo_empty && (starve_q == S_LIM)) begin
            stall_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            starve_q     <= '0;
            stall_q      <= 1'b0;
            write_ctrl_q <= 1'b0;
            write_addr_q <= '0;
            write_data_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            starve_q     <= starve_d;
            stall_q      <= stall_d;
            write_ctrl_q <= write_ctrl_d;
            write_addr_q <= write_addr_d;
            write_data_q <= write_data_d;
        end
    end

    // Storage needs no reset: validity is tracked by the pointers and count.
    always_ff @(posedge clk_i) begin
        if (push) begin
            addr_mem_q[wr_ptr_q] <= lu_addr_i;
            data_mem_q[wr_ptr_q] <= lu_data_i;
        end
    end

    // An entry is live when its distance from the read pointer is below count.
    always_comb begin
        fifo_hit = 1'b0;
        offset   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset = PW'(i) - rd_ptr_q;
            if ((CW'(offset) < count_q) && (addr_mem_q[i] == chk_addr_i)) fifo_hit = 1'b1;
        end
    end

    assign out_hit = write_ctrl_q && (write_addr_q == chk_addr_i);

`ifdef WB_FORWARD_EN
    assign chk_pend_o = (chk_addr_i != 5'd0) && fifo_hit;
    assign fwd_hit_o  = (chk_addr_i != 5'd0) && out_hit;
    assign fwd_data_o = write_data_q;
`else
    assign chk_pend_o = (chk_addr_i != 5'd0) && (fifo_hit || out_hit);
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
module tb_writeback_arbiter;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int SMAX   = 8;

    logic              clk_i = 1'b0;
    logic              rst_n_i;
    logic              pipe_valid_i;
    logic [4:0]        pipe_addr_i;
    logic [DATA_W-1:0] pipe_data_i;
    logic              lu_valid_i;
    logic              lu_ready_o;
    logic [4:0]        lu_addr_i;
    logic [DATA_W-1:0] lu_data_i;
    logic              write_ctrl_o;
    logic [4:0]        write_addr_o;
    logic [DATA_W-1:0] write_data_o;
    logic              pipe_stall_o;
    logic [4:0]        chk_addr_i;
    logic              chk_pend_o;
    logic [2:0]        count_o;

    writeback_arbiter #(.DATA_W(DATA_W), .DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .pipe_valid_i(pipe_valid_i), .pipe_addr_i(pipe_addr_i), .pipe_data_i(pipe_data_i),
        .lu_valid_i(lu_valid_i), .lu_ready_o(lu_ready_o),
        .lu_addr_i(lu_addr_i), .lu_data_i(lu_data_i),
        .write_ctrl_o(write_ctrl_o), .write_addr_o(write_addr_o), .write_data_o(write_data_o),
        .pipe_stall_o(pipe_stall_o), .chk_addr_i(chk_addr_i), .chk_pend_o(chk_pend_o),
        .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [4:0]        a;
        logic [DATA_W-1:0] d;
    } ent_t;

    ent_t              m_q[$];
    bit                m_ctrl;
    logic [4:0]        m_addr;
    logic [DATA_W-1:0] m_data;
    int                m_starve;
    bit                m_stall;
    int                checks = 0;
    int                errors = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_q.delete();
        m_ctrl   = 0;
        m_addr   = '0;
        m_data   = '0;
        m_starve = 0;
        m_stall  = 0;
    endfunction

    function automatic bit model_pend(input logic [4:0] ca);
        bit hit = 0;
        if (ca == 0) return 0;
        foreach (m_q[i]) if (m_q[i].a == ca) hit = 1;
        if (m_ctrl && m_addr == ca) hit = 1;
        return hit;
    endfunction

    task automatic check_outputs();
        check_val("write_ctrl", 64'(write_ctrl_o), 64'(m_ctrl));
        check_val("write_addr", 64'(write_addr_o), 64'(m_addr));
        check_val("write_data", 64'(write_data_o), 64'(m_data));
        check_val("count", 64'(count_o), 64'(m_q.size()));
        check_val("lu_ready", 64'(lu_ready_o), 64'(m_q.size() != DEPTH));
        check_val("stall", 64'(pipe_stall_o), 64'(m_stall));
        check_val("chk_pend", 64'(chk_pend_o), 64'(model_pend(chk_addr_i)));
    endtask

    // One clock slot: drive, check current state against the model, advance
    // the model by the arbitration rules, then move past the edge.
    task automatic step(input bit pv, input logic [4:0] pa, input logic [DATA_W-1:0] pd,
                        input bit lv, input logic [4:0] la, input logic [DATA_W-1:0] ld,
                        input logic [4:0] ca);
        bit   pw, do_pop;
        int   n;
        ent_t e;
        pipe_valid_i = pv; pipe_addr_i = pa; pipe_data_i = pd;
        lu_valid_i = lv;   lu_addr_i = la;   lu_data_i = ld;
        chk_addr_i = ca;
        #1;
        check_outputs();
        n      = m_q.size();
        pw     = pv && (pa != 0);
        do_pop = !pw && (n > 0);
        if (pw) begin
            m_ctrl = 1; m_addr = pa; m_data = pd;
        end else if (do_pop) begin
            e = m_q.pop_front();
            m_ctrl = 1; m_addr = e.a; m_data = e.d;
        end else begin
            m_ctrl = 0;
        end
        if (do_pop) begin
            m_starve = 0; m_stall = 0;
        end else if (n == 0) begin
            m_starve = 0;
        end else begin
            if (SMAX != 0 && m_starve == SMAX) m_stall = 1;
            if (m_starve < SMAX) m_starve++;
        end
        if (lv && n < DEPTH && la != 0) begin
            e.a = la; e.d = ld;
            m_q.push_back(e);
        end
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int prob;
        rst_n_i = 1'b0;
        pipe_valid_i = 0; pipe_addr_i = 0; pipe_data_i = 0;
        lu_valid_i = 0;   lu_addr_i = 0;   lu_data_i = 0;
        chk_addr_i = 0;
        model_reset();
        repeat (2) @(negedge clk_i);
        check_val("rst_ctrl", 64'(write_ctrl_o), 0);
        check_val("rst_addr", 64'(write_addr_o), 0);
        check_val("rst_data", 64'(write_data_o), 0);
        check_val("rst_count", 64'(count_o), 0);
        check_val("rst_stall", 64'(pipe_stall_o), 0);
        rst_n_i = 1'b1;

        // pipeline write latency
        step(1, 5, 32'h1234, 0, 0, 0, 0);
        check_val("t1_ctrl", 64'(write_ctrl_o), 1);
        check_val("t1_addr", 64'(write_addr_o), 5);
        check_val("t1_data", 64'(write_data_o), 64'h1234);
        idle(1);
        check_val("t1_ctrl_off", 64'(write_ctrl_o), 0);
        check_val("t1_addr_hold", 64'(write_addr_o), 5);

        // long-latency push then pop
        step(0, 0, 0, 1, 7, 32'hA5A5, 0);
        check_val("t2_count1", 64'(count_o), 1);
        check_val("t2_ctrl_early", 64'(write_ctrl_o), 0);
        idle(1);
        check_val("t2_ctrl", 64'(write_ctrl_o), 1);
        check_val("t2_addr", 64'(write_addr_o), 7);
        check_val("t2_data", 64'(write_data_o), 64'hA5A5);
        check_val("t2_count0", 64'(count_o), 0);

        // fill while pipe busy, then drain in order
        for (int i = 0; i < 4; i++) step(1, 5'(10+i), 32'(i), 1, 5'(20+i), 32'(100+i), 0);
        check_val("t3_count", 64'(count_o), 4);
        check_val("t3_ready", 64'(lu_ready_o), 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 0, 0, 0);
            check_val("t3_order", 64'(write_addr_o), 64'(20+i));
        end
        check_val("t3_empty", 64'(count_o), 0);

        // starvation threshold
        step(1, 1, 32'h11, 1, 9, 32'h99, 0);
        for (int i = 0; i < 9; i++) begin
            step(1, 5'(2+i), 32'(i), 0, 0, 0, 0);
            if (i == 7) check_val("t4_no_stall", 64'(pipe_stall_o), 0);
        end
        check_val("t4_stall", 64'(pipe_stall_o), 1);
        idle(1);
        check_val("t4_pop_addr", 64'(write_addr_o), 9);
        check_val("t4_stall_clr", 64'(pipe_stall_o), 0);

        // r0 is never written nor stored; hazard query on FIFO contents
        step(1, 0, 32'hDEAD, 1, 0, 32'hBEEF, 0);
        check_val("t5_ctrl", 64'(write_ctrl_o), 0);
        check_val("t5_count", 64'(count_o), 0);
        step(1, 1, 32'h1, 1, 3, 32'h33, 0);
        chk_addr_i = 3; #1;
        check_val("t5_pend3", 64'(chk_pend_o), 1);
        chk_addr_i = 4; #1;
        check_val("t5_pend4", 64'(chk_pend_o), 0);
        idle(2);

        // mid-operation reset
        for (int i = 0; i < 3; i++) step(1, 5'(4+i), 32'(i), 1, 5'(12+i), 32'(i), 0);
        rst_n_i = 1'b0; #1;
        check_val("t6_count", 64'(count_o), 0);
        check_val("t6_ctrl", 64'(write_ctrl_o), 0);
        model_reset();
        @(negedge clk_i);
        rst_n_i = 1'b1;
        idle(5);

        // randomized traffic with varying pipeline load
        prob = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 150 == 0) begin
                case ($urandom_range(0, 3))
                    0: prob = 20;
                    1: prob = 60;
                    2: prob = 90;
                    default: prob = 100;
                endcase
            end
            step($urandom_range(0, 99) < prob, 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
                 5'($urandom_range(0, 7)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
